// File: rtl/axis_bram_writer.sv
// axis_bram_writer: writes each AXI-Stream beat to consecutive BRAM addresses under a start/busy/complete/error FSM.
// Optional: define AXIS_BRAM_WRITER_WRACK_EN to add bram_wrack and hold each write until it is acknowledged.
module axis_bram_writer #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ADDR_STEP  = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    fsm_clk,
    input  logic                    rst,
    input  logic                    operation_start,
    input  logic [ADDR_WIDTH:0]     data_size,
    output logic                    operation_busy,
    output logic                    operation_complete,
    output logic                    operation_error,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
`ifdef AXIS_BRAM_WRITER_WRACK_EN
    input  logic                    bram_wrack,
`endif
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wrdata
);
    localparam int unsigned           WE_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LP_STEP = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [ADDR_WIDTH:0]   LP_ONE  = (ADDR_WIDTH+1)'(1);

`ifdef AXIS_BRAM_WRITER_WRACK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_DONE, ST_ERROR, ST_WAIT_ACK} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE, ST_ERROR} state_t;
`endif

    state_t                r_state;
    state_t                w_state_next;
    state_t                w_beat_dest;
    logic [ADDR_WIDTH:0]   r_size;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [DATA_WIDTH-1:0] r_bram_wrdata;
    logic                  r_bram_en;
    logic                  r_busy;
    logic                  r_complete;
    logic                  w_start;
    logic                  w_size_zero;
    logic                  w_accept;
    logic                  w_last_cnt;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
    state_t                r_pend_dest;
`endif

    assign s_axis_tready = (r_state == ST_WRITE);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_start       = operation_start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    assign w_size_zero   = (data_size == '0);
    assign w_cnt_next    = r_cnt + LP_ONE;
    assign w_last_cnt    = (w_cnt_next == r_size);

    // Destination after the beat offered now: count and tlast must agree to finish cleanly.
    always_comb begin
        w_beat_dest = ST_WRITE;
        if (w_last_cnt && s_axis_tlast) begin
            w_beat_dest = ST_DONE;
        end else if (w_last_cnt || s_axis_tlast) begin
            w_beat_dest = ST_ERROR;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (operation_start) begin
                    w_state_next = w_size_zero ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_accept) begin
`ifdef AXIS_BRAM_WRITER_WRACK_EN
                    w_state_next = ST_WAIT_ACK;
`else
                    w_state_next = w_beat_dest;
`endif
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
            ST_WAIT_ACK: begin
                if (bram_wrack) begin
                    w_state_next = r_pend_dest;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            r_size        <= '0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_bram_en     <= 1'b0;
            r_bram_addr   <= '0;
            r_bram_wrdata <= '0;
            r_busy        <= 1'b0;
            r_complete    <= 1'b0;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
            r_pend_dest   <= ST_IDLE;
`endif
        end else begin
`ifdef AXIS_BRAM_WRITER_WRACK_EN
            r_busy <= (w_state_next == ST_WRITE) || (w_state_next == ST_WAIT_ACK);
`else
            r_busy <= (w_state_next == ST_WRITE);
`endif
            // Completion is reported in the cycle after DONE, i.e. one cycle after the final write.
            r_complete <= (r_state == ST_DONE);
            if (w_start && !w_size_zero) begin
                r_size <= data_size;
                r_cnt  <= '0;
                r_addr <= BASE_ADDR;
            end
            if (w_accept) begin
                r_cnt         <= w_cnt_next;
                r_addr        <= r_addr + LP_STEP;
                r_bram_addr   <= r_addr;
                r_bram_wrdata <= s_axis_tdata;
            end
`ifdef AXIS_BRAM_WRITER_WRACK_EN
            if (w_accept) begin
                r_bram_en   <= 1'b1;
                r_pend_dest <= w_beat_dest;
            end else if ((r_state == ST_WAIT_ACK) && bram_wrack) begin
                r_bram_en <= 1'b0;
            end
`else
            r_bram_en <= w_accept;
`endif
        end
    end

    assign operation_busy     = r_busy;
    assign operation_complete = r_complete;
    assign operation_error    = (r_state == ST_ERROR);
    assign bram_en            = r_bram_en;
    assign bram_we            = {WE_W{r_bram_en}};
    assign bram_addr          = r_bram_addr;
    assign bram_wrdata        = r_bram_wrdata;

endmodule

// File: tb/tb_axis_bram_writer.sv
// Randomized self-checking bench for axis_bram_writer; the reference model predicts the write sequence
// and final status of each transfer from its size and tlast position.
module tb_axis_bram_writer;
    localparam int DW      = 16;
    localparam int AW      = 32;
    localparam int STEP    = 2;
    localparam int ACK_DLY = 3;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
    localparam int EN_PER  = ACK_DLY + 1;
`else
    localparam int EN_PER  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          operation_start;
    logic [AW:0]   data_size;
    logic          operation_busy;
    logic          operation_complete;
    logic          operation_error;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          bram_en;
    logic [DW/8-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata;
    logic          w_ack;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
    logic          bram_wrack;
    assign w_ack = bram_wrack;
`else
    assign w_ack = 1'b1;
`endif

    always #5 clk = ~clk;

    axis_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .fsm_clk            (clk),
        .rst                (rst),
        .operation_start    (operation_start),
        .data_size          (data_size),
        .operation_busy     (operation_busy),
        .operation_complete (operation_complete),
        .operation_error    (operation_error),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
`ifdef AXIS_BRAM_WRITER_WRACK_EN
        .bram_wrack         (bram_wrack),
`endif
        .bram_en            (bram_en),
        .bram_we            (bram_we),
        .bram_addr          (bram_addr),
        .bram_wrdata        (bram_wrdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus monitor: committed writes, enable protocol violations, completion timing.
    logic [AW+DW-1:0] obs_q[$];
    logic hs_prev = 1'b0;
    int   cyc = 0, en_bad = 0, en_cyc = 0, n_complete = 0, cmp_cyc = 0, last_wr_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            hs_prev <= 1'b0;
        end else begin
            hs_prev <= s_axis_tvalid && s_axis_tready;
`ifdef AXIS_BRAM_WRITER_WRACK_EN
            en_bad <= en_bad + int'(bram_en && s_axis_tready) + int'(bram_en && (bram_we != '1));
`else
            en_bad <= en_bad + int'(bram_en != hs_prev) + int'(bram_en && (bram_we != '1));
`endif
            if (bram_en) en_cyc <= en_cyc + 1;
            if (bram_en && w_ack) begin
                obs_q.push_back({bram_addr, bram_wrdata});
                last_wr_cyc <= cyc;
            end
            if (operation_complete) begin
                n_complete <= n_complete + 1;
                cmp_cyc    <= cyc;
            end
        end
    end

`ifdef AXIS_BRAM_WRITER_WRACK_EN
    initial begin
        int run;
        run = 0;
        bram_wrack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bram_wrack = 1'b0;
            if (bram_en) begin
                run++;
                if (run == ACK_DLY + 1) begin
                    bram_wrack = 1'b1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    end
`endif

    task automatic send_beat(input logic [DW-1:0] d, input bit last);
        bit hs;
        int w;
        hs = 1'b0;
        w  = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!hs && w < 40) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk); #1;
            w++;
        end
        check_eq("beat_accepted", hs, 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_start(input int size);
        operation_start = 1'b1;
        data_size       = (AW+1)'(size);
        @(posedge clk); #1;
        operation_start = 1'b0;
        @(negedge clk);
        check_eq("busy_after_start", operation_busy, size != 0);
        check_eq("err_after_start", operation_error, size == 0);
        @(posedge clk); #1;
    endtask

    // tl_pos: 1-based beat carrying tlast (size+1 or 0 = none); gap_mode 0 none, 1 one idle cycle, 2 random 0..2.
    task automatic run_xfer(input int size, input int tl_pos, input int gap_mode, input bit fixed);
        logic [DW-1:0] bd[$];
        bit            bl[$];
        int nacc, q0, c0, e0, n0, g;
        bit ok;
        for (int i = 0; i < size; i++) begin
            bd.push_back(fixed ? DW'(32'hA1 + i) : DW'($urandom));
            bl.push_back(i + 1 == tl_pos);
        end
        nacc = 0;
        ok   = 1'b0;
        for (int i = 0; i < size; i++) begin
            nacc = i + 1;
            if (i + 1 == size || bl[i]) begin
                ok = (i + 1 == size) && bl[i];
                break;
            end
        end
        q0 = obs_q.size();
        c0 = n_complete;
        e0 = en_bad;
        n0 = en_cyc;
        do_start(size);
        for (int i = 0; i < nacc; i++) begin
            send_beat(bd[i], bl[i]);
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (g) begin @(posedge clk); #1; end
        end
        // A stray beat after termination must never be written.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = DW'($urandom);
        s_axis_tlast  = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("n_writes", obs_q.size() - q0, nacc);
        for (int i = 0; i < nacc && q0 + i < obs_q.size(); i++) begin
            check_eq("wr_addr", obs_q[q0+i][AW+DW-1:DW], 64'(i * STEP));
            check_eq("wr_data", obs_q[q0+i][DW-1:0], bd[i]);
        end
        check_eq("error_flag", operation_error, !ok);
        check_eq("busy_end", operation_busy, 0);
        check_eq("tready_end", s_axis_tready, 0);
        check_eq("complete_count", n_complete - c0, ok);
        check_eq("en_protocol", en_bad - e0, 0);
        check_eq("en_cycles", en_cyc - n0, nacc * EN_PER);
`ifndef AXIS_BRAM_WRITER_WRACK_EN
        if (ok) check_eq("complete_latency", cmp_cyc - last_wr_cyc, 1);
`endif
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_xfer();
        do_start(5);
        send_beat(16'h5A5A, 1'b0);
        send_beat(16'hC3C3, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_outputs", {bram_en, bram_we, bram_addr, bram_wrdata, operation_busy,
                                 operation_complete, operation_error, s_axis_tready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int sz;
        rst             = 1'b1;
        operation_start = 1'b0;
        data_size       = '0;
        s_axis_tdata    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs", {bram_en, bram_we, bram_addr, bram_wrdata, operation_busy,
                                   operation_complete, operation_error, s_axis_tready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(4, 4, 0, 1'b1);
        run_xfer(3, 3, 1, 1'b0);
        run_xfer(4, 2, 0, 1'b0);
        run_xfer(1, 1, 0, 1'b0);
        run_xfer(2, 3, 0, 1'b0);
        run_xfer(0, 1, 0, 1'b0);
        run_xfer(0, 1, 0, 1'b0);
        run_xfer(2, 2, 0, 1'b0);
        reset_mid_xfer();
        run_xfer(3, 3, 2, 1'b0);
        for (int k = 0; k < 24; k++) begin
            sz = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            run_xfer(sz, int'($urandom_range(1, sz + 1)), 2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_bram_writer.md
Name: axis_bram_writer

Overview:
Stream-to-BRAM write engine; the inverse of the memory control unit's BRAM-read/AXI-Stream-out path. It accepts one AXI-Stream result channel from the data processor and writes each beat to consecutive BRAM addresses through a BRAM control port. A single global FSM in the fsm_clk domain handles start, busy, complete and error, using the same control/interrupt convention as the MCU.

Parameters:
DATA_WIDTH, 16, tdata and BRAM write-data width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, BRAM address width in bits.
ADDR_STEP, DATA_WIDTH/8, address increment per beat (byte addressing).
BASE_ADDR, 0, address of the first beat.

Ports:
fsm_clk  in  1  block clock.
rst  in  1  asynchronous active-high reset.
operation_start  in  1  single-cycle start request; ignored while busy.
data_size  in  ADDR_WIDTH+1  number of beats expected; sampled on an accepted start.
operation_busy  out  1  high from accepted start until DONE or ERROR.
operation_complete  out  1  one-cycle pulse on successful end of transfer.
operation_error  out  1  high in ERROR state.
s_axis_tdata  in  DATA_WIDTH  input stream data.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  input beat ready.
s_axis_tlast  in  1  marks the final beat of the transfer.
bram_en  out  1  BRAM enable.
bram_we  out  DATA_WIDTH/8  byte write enables; all ones when writing.
bram_addr  out  ADDR_WIDTH  BRAM address.
bram_wrdata  out  DATA_WIDTH  BRAM write data.

Behaviour:
- FSM states: IDLE, WRITE, DONE, ERROR; WAIT_ACK exists only with the optional feature.
- Reset (asynchronous, any state): IDLE. All outputs 0. Internal counter and address cleared. Any write in flight is dropped.
- IDLE, operation_start=1, data_size!=0: latch size, cnt=0, addr=BASE_ADDR, go to WRITE.
- IDLE, operation_start=1, data_size==0: go to ERROR. No BRAM access.
- WRITE: s_axis_tready=1 (combinational from state).
- Handshake rule: a beat is accepted when tvalid & tready.
- On an accepted beat, the next cycle registers bram_en=1, bram_we=all ones, bram_addr=addr, bram_wrdata=tdata. Write latency: 1 cycle from handshake.
- Each accepted beat: addr+=ADDR_STEP (wraps modulo 2^ADDR_WIDTH, no error), cnt+=1.
- bram_en/bram_we stay high only in cycles following an accepted beat; otherwise 0. bram_addr and bram_wrdata hold their last values.
- Accepted beat with cnt+1==size and tlast=1: go to DONE.
- Accepted beat with cnt+1==size and tlast=0: go to ERROR (tlast missing).
- Accepted beat with cnt+1<size and tlast=1: go to ERROR (early tlast).
- In every terminating case above, the final beat is still written to BRAM.
- DONE: operation_complete=1 for exactly one cycle, busy=0, then IDLE. A start arriving in DONE is ignored.
- ERROR: operation_error=1, tready=0, busy=0. Stays in ERROR until operation_start=1, which clears the error and is treated as an IDLE start in the same cycle.
- Back-to-back beats (tvalid held high) write one word per cycle with no bubbles.
- operation_busy is registered; it rises the cycle after an accepted start.

Optional Feature:
Macro AXIS_BRAM_WRITER_WRACK_EN.
- Defined: adds input port bram_wrack (1 bit) and the WAIT_ACK state.
  - After each accepted beat, go to WAIT_ACK. tready=0 there; bram_en/bram_we are held high until bram_wrack=1.
  - On ack, deassert en/we and return to WRITE, or go to DONE/ERROR per the last-beat rules.
  - An ack arriving in the same cycle that en rises counts.
  - Throughput is at most one beat per two cycles.
- Undefined: no bram_wrack port; writes are fire-and-forget, and the behaviour is as above.

Test Plan:
- data_size=4, beats 0xA1..0xA4 back-to-back, tlast on the 4th -> bram_addr 0,2,4,6 with data A1..A4 on consecutive cycles; operation_complete pulses once, 1 cycle after the last write.
- data_size=3, tvalid toggled 1/0 each cycle -> exactly 3 writes, en never high on idle cycles, addresses 0,2,4, complete asserted.
- data_size=4, tlast on beat 2 -> 2 writes, operation_error=1, tready=0; a new start with size 1 and a tlast beat -> error clears, 1 write at addr 0, complete.
- data_size=2, no tlast on beat 2 -> 2 writes then ERROR; data_size=0 start -> ERROR with no bram_en activity.
- rst asserted mid-transfer after 2 of 5 beats -> all outputs 0 immediately; the next start writes from BASE_ADDR.
- With AXIS_BRAM_WRITER_WRACK_EN, ack delayed 3 cycles per write, size=2 -> en held 4 cycles per beat, tready low during WAIT_ACK, complete after the second ack.
